// File: rtl/seq_detect_pkg.sv
// Purpose : shared constants and helpers for the programmable sequence detector.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: reset-default constants, length-field width helper, cfg_len clamp.
package seq_detect_pkg;

    localparam int              DEF_MAX_LEN  = 8;
    localparam logic [31:0]     DEF_PATTERN  = 32'h0000_000B;   // "1011", MSB received first
    localparam int              DEF_LEN      = 4;
    localparam bit              DEF_OVERLAP  = 1'b1;
    localparam int              DEF_CNT_W    = 16;

    // Width of a field able to hold 0..max_len.
    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // A zero length would match nothing sensible, and lengths beyond the
    // history register cannot be compared, so both are pulled into range.
    function automatic int clamp_len(input int l, input int max_len);
        if (l == 0)
            return 1;
        else if (l > max_len)
            return max_len;
        else
            return l;
    endfunction

endpackage

// File: rtl/seq_detect_prog_if.sv
// Purpose : serial data, configuration and status bundle for seq_detect_prog.
// Latency : n/a (wiring only).
// Backpressure: none; inp_valid qualifies data, the detector always accepts.
// Signals : inp_bit/inp_valid, cfg_load/cfg_pattern/cfg_len/cfg_overlap,
//           seq_seen, busy, match_count (only with SEQ_DETECT_MATCH_COUNT_EN).
interface seq_detect_prog_if
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = DEF_CNT_W
);
    localparam int LW = len_w(MAX_LEN);

    logic               inp_bit;
    logic               inp_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               seq_seen;
    logic               busy;
`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [CNT_W-1:0]   match_count;

    modport master (
        output inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  seq_seen, busy, match_count
    );
    modport slave (
        input  inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output seq_seen, busy, match_count
    );
`else
    modport master (
        output inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  seq_seen, busy
    );
    modport slave (
        input  inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output seq_seen, busy
    );
`endif

endinterface

// File: rtl/seq_detect_prog_seq_window_cmp.sv
// Purpose : masked compare of the low len history bits against the pattern.
// Latency : combinational.
// Backpressure: none.
// Ports   : i_hist_n, i_pat, i_len, i_fill_n in; o_match out.
module seq_window_cmp
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LW      = len_w(DEF_MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] i_hist_n,
    input  logic [MAX_LEN-1:0] i_pat,
    input  logic [LW-1:0]      i_len,
    input  logic [LW-1:0]      i_fill_n,
    output logic               o_match
);

    logic [MAX_LEN-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            w_mask[i] = (i < int'(i_len));
    end

    // Bits above len are don't-care; the window must also be fully populated
    // with bits received since the last clear.
    assign o_match = (((i_hist_n ^ i_pat) & w_mask) == '0) && (i_fill_n >= i_len);

endmodule

// File: rtl/seq_detect_prog.sv
// Purpose : programmable serial pattern detector, one-cycle match pulse.
// Latency : seq_seen high the cycle after the edge sampling the final pattern bit.
// Backpressure: none; bits accepted whenever inp_valid is high (cfg_load wins).
// Ports   : clk, reset (sync, active-high); bus = seq_detect_prog_if.slave.
// Option  : SEQ_DETECT_MATCH_COUNT_EN adds the saturating match_count output.
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN         = DEF_MAX_LEN,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(DEF_PATTERN),
    parameter int                 DEFAULT_LEN     = DEF_LEN,
    parameter bit                 DEFAULT_OVERLAP = DEF_OVERLAP,
    parameter int                 CNT_W           = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    seq_detect_prog_if.slave  bus
);

    localparam int LW = len_w(MAX_LEN);

    logic [MAX_LEN-1:0] r_hist;
    logic [LW-1:0]      r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_len;
    logic               r_ovl;
    logic               r_seen;
    logic               r_busy;

    logic [MAX_LEN-1:0] w_hist_n;
    logic [LW-1:0]      w_fill_n;
    logic [LW-1:0]      w_fill_next;
    logic [LW-1:0]      w_cfg_len;
    logic               w_match;

    assign w_hist_n  = {r_hist[MAX_LEN-2:0], bus.inp_bit};
    assign w_fill_n  = (r_fill >= LW'(MAX_LEN)) ? r_fill : r_fill + LW'(1);
    assign w_cfg_len = LW'(clamp_len(int'(bus.cfg_len), MAX_LEN));

    seq_window_cmp #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW)
    ) u_cmp (
        .i_hist_n (w_hist_n),
        .i_pat    (r_pat),
        .i_len    (r_len),
        .i_fill_n (w_fill_n),
        .o_match  (w_match)
    );

    // Non-overlapping mode restarts the window after a hit so the next match
    // needs len fresh bits.
    always_comb begin
        w_fill_next = r_fill;
        if (bus.cfg_load)
            w_fill_next = '0;
        else if (bus.inp_valid)
            w_fill_next = (w_match && !r_ovl) ? '0 : w_fill_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= DEFAULT_PATTERN;
            r_len  <= LW'(DEFAULT_LEN);
            r_ovl  <= DEFAULT_OVERLAP;
            r_seen <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_fill <= w_fill_next;
            r_busy <= (w_fill_next != '0);
            if (bus.cfg_load) begin
                // History is left alone: fill=0 keeps stale bits out of any compare.
                r_pat  <= bus.cfg_pattern;
                r_len  <= w_cfg_len;
                r_ovl  <= bus.cfg_overlap;
                r_seen <= 1'b0;
            end else if (bus.inp_valid) begin
                r_hist <= w_hist_n;
                r_seen <= w_match;
            end else begin
                r_seen <= 1'b0;
            end
        end
    end

    assign bus.seq_seen = r_seen;
    assign bus.busy     = r_busy;

`ifdef SEQ_DETECT_MATCH_COUNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || bus.cfg_load)
            r_cnt <= '0;
        else if (bus.inp_valid && w_match && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign bus.match_count = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_detect_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: list of bits accepted since the last clear.
    int         q[$];
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    bit         e_seen;
    bit         e_busy;
    int         e_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pat  = 8'b0000_1011;
        m_len  = 4;
        m_ovl  = 1'b1;
        e_seen = 1'b0;
        e_cnt  = 0;
    endtask

    function automatic bit window_hit();
        if (q.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++)
            if (q[q.size()-1-k] != int'(m_pat[k])) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: drive, apply the model to what was driven, then check.
    task automatic cyc(input bit b, input bit v, input bit ld = 1'b0,
                       input logic [7:0] p = 8'h00, input int l = 0,
                       input bit o = 1'b0, input bit r = 1'b0);
        bit hit;
        reset           = r;
        bus.inp_bit     = b;
        bus.inp_valid   = v;
        bus.cfg_load    = ld;
        bus.cfg_pattern = p;
        bus.cfg_len     = l[3:0];
        bus.cfg_overlap = o;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (ld) begin
            m_pat  = p;
            m_len  = (l == 0) ? 1 : (l > MAX_LEN) ? MAX_LEN : l;
            m_ovl  = o;
            q.delete();
            e_seen = 1'b0;
            e_cnt  = 0;
        end else if (v) begin
            q.push_back(int'(b));
            if (q.size() > MAX_LEN) void'(q.pop_front());
            hit    = window_hit();
            e_seen = hit;
            if (hit) begin
                if (e_cnt < (1 << CNT_W) - 1) e_cnt++;
                if (!m_ovl) q.delete();
            end
        end else begin
            e_seen = 1'b0;
        end
        e_busy = (q.size() != 0);
        #1;
        chk("seq_seen", 32'(bus.seq_seen), 32'(e_seen));
        chk("busy", 32'(bus.busy), 32'(e_busy));
`ifdef SEQ_DETECT_MATCH_COUNT_EN
        chk("match_count", 32'(bus.match_count), 32'(e_cnt));
`endif
    endtask

    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            cyc(bits[i], 1'b1);
    endtask

    int pulses;

    initial begin
        model_reset();
        reset = 1'b1;
        bus.inp_bit = 1'b0; bus.inp_valid = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 1'b0;

        // Reset state.
        cyc(0, 0, .r(1)); cyc(0, 0, .r(1));
        chk("reset_seen_const", 32'(bus.seq_seen), 32'd0);
        chk("reset_busy_const", 32'(bus.busy), 32'd0);

        // Default 1011 overlapping: 1011011 -> pulses after bits 4 and 7.
        pulses = 0;
        for (int i = 6; i >= 0; i--) begin
            logic [6:0] s; s = 7'b1011011;
            cyc(s[i], 1'b1);
            if (bus.seq_seen) pulses++;
        end
        chk("ovl_pulse_count", 32'(pulses), 32'd2);

        // Non-overlapping.
        cyc(0, 0, 1, 8'b1011, 4, 0);
        stream(16'b1011011, 7);

        // Gaps are transparent.
        cyc(0, 0, 1, 8'b1011, 4, 0);
        cyc(1, 1); cyc(0, 0); cyc(0, 1); cyc(1, 0); cyc(0, 0); cyc(1, 1);
        cyc(1, 1);
        chk("gap_pulse_const", 32'(bus.seq_seen), 32'd1);

        // Pattern 110, len 3, overlapping; then load mid-stream with valid high.
        cyc(0, 0, 1, 8'b1111_0110, 3, 1);
        stream(16'b110110, 6);
        cyc(1, 1); cyc(1, 1);
        cyc(0, 1, 1, 8'b0000_0110, 3, 1);
        cyc(0, 1); cyc(1, 1); cyc(1, 1); cyc(0, 1);

        // Reset mid-sequence.
        cyc(0, 0, 1, 8'b1011, 4, 1);
        stream(16'b101, 3);
        cyc(1, 1, .r(1));
        cyc(1, 1);
        chk("post_reset_seen_const", 32'(bus.seq_seen), 32'd0);

        // len 0 -> 1: every 1 pulses; count saturates at 3.
        cyc(0, 0, 1, 8'h01, 0, 1);
        stream(16'b110111, 6);

        // len MAX_LEN+3 -> MAX_LEN.
        cyc(0, 0, 1, 8'hA5, MAX_LEN + 3, 1);
        stream(16'hA5A5, 16);
        cyc(0, 0, 1, 8'hA5, MAX_LEN + 3, 0);
        stream(16'hA5A5, 16);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            int sel;
            sel = $urandom_range(0, 199);
            if (sel == 0)
                cyc(1'($urandom), 1'($urandom), .r(1));
            else if (sel < 5)
                cyc(1'($urandom), 1'($urandom), 1, 8'($urandom),
                    (sel == 1) ? $urandom_range(0, 11) : $urandom_range(1, 4),
                    1'($urandom));
            else
                cyc(1'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
